// File: rtl/alu_pkg.sv
// Shared ALU definitions: datapath width, operation encodings, helpers.
package alu_pkg;

  localparam int unsigned XLEN = 32;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'b0000,
    ALU_SUB  = 4'b0001,
    ALU_SLL  = 4'b0010,
    ALU_SLT  = 4'b0100,
    ALU_SLTU = 4'b0110,
    ALU_XOR  = 4'b1000,
    ALU_SRL  = 4'b1010,
    ALU_SRA  = 4'b1011,
    ALU_OR   = 4'b1100,
    ALU_AND  = 4'b1110
  } alu_op_e;

  // True for operations whose B operand is a shift amount.
  function automatic logic is_shift(input logic [3:0] sel);
    return (sel == ALU_SLL) || (sel == ALU_SRL) || (sel == ALU_SRA);
  endfunction

endpackage

// File: rtl/alu.sv
// Purely combinational ALU shared by both requesters.
module alu
  import alu_pkg::*;
(
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic [3:0]      sel,
  output logic [XLEN-1:0] y
);

  // Operation decode; unknown codes fall back to addition.
  always_comb begin
    y = a + b;
    case (sel)
      ALU_ADD:  y = a + b;
      ALU_SUB:  y = a - b;
      ALU_SLL:  y = a << b;
      ALU_SLT:  y = {{(XLEN-1){1'b0}}, ($signed(a) < $signed(b))};
      ALU_SLTU: y = {{(XLEN-1){1'b0}}, (a < b)};
      ALU_XOR:  y = a ^ b;
      ALU_SRL:  y = a >> b;
      ALU_SRA:  y = $unsigned($signed(a) >>> b);
      ALU_OR:   y = a | b;
      ALU_AND:  y = a & b;
      default:  y = a + b;
    endcase
  end

endmodule

// File: rtl/alu_arbiter.sv
// Two-requester arbiter in front of a single ALU with a one-entry result register.
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int unsigned FIXED_PRIO   = 0,
  parameter int unsigned STARVE_LIMIT = 15
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [31:0] req0_a,
  input  logic [31:0] req0_b,
  input  logic [3:0]  req0_sel,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [31:0] req1_a,
  input  logic [31:0] req1_b,
  input  logic [3:0]  req1_sel,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic        rsp_id,
  output logic [31:0] rsp_data,
  output logic        busy
);

  localparam int unsigned SCW = (STARVE_LIMIT < 2) ? 1 : $clog2(STARVE_LIMIT + 1);

  logic            last_grant;
  logic [SCW-1:0]  starve_cnt;
  logic            starve_hit;
  logic            grant1;
  logic            slot_free;
  logic            accept;
  logic [XLEN-1:0] op_a;
  logic [XLEN-1:0] op_b;
  logic [3:0]      op_sel;
  logic [XLEN-1:0] alu_y;

  assign starve_hit = (starve_cnt >= SCW'(STARVE_LIMIT));
  assign slot_free  = !rsp_valid || rsp_ready;

  // Pick the winner from valids and history only, never from operand values.
  always_comb begin
    grant1 = 1'b0;
    if (req1_valid) begin
      if (!req0_valid)          grant1 = 1'b1;
      else if (FIXED_PRIO != 0) grant1 = starve_hit;
      else                      grant1 = (last_grant == 1'b0);
    end
  end

  assign req0_ready = rst_n && slot_free && req0_valid && !grant1;
  assign req1_ready = rst_n && slot_free && grant1;
  assign accept     = req0_ready || req1_ready;

  // Route the granted requester to the ALU, clamping shift amounts to 5 bits.
  always_comb begin
    op_a   = grant1 ? req1_a   : req0_a;
    op_b   = grant1 ? req1_b   : req0_b;
    op_sel = grant1 ? req1_sel : req0_sel;
    if (is_shift(op_sel)) op_b = {{(XLEN-5){1'b0}}, op_b[4:0]};
  end

  alu u_alu (
    .a   (op_a),
    .b   (op_b),
    .sel (op_sel),
    .y   (alu_y)
  );

  // Result register: load on accept, drop valid on drain, hold otherwise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      rsp_id    <= 1'b0;
    end else if (accept) begin
      rsp_valid <= 1'b1;
      rsp_data  <= alu_y;
      rsp_id    <= grant1;
    end else if (rsp_ready) begin
      rsp_valid <= 1'b0;
    end
  end

  // Round-robin history; reset value 1 lets requester 0 win the first tie.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      last_grant <= 1'b1;
    else if (accept) last_grant <= grant1;
  end

  // Requester 1 starvation counter, only meaningful in fixed-priority mode.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                          starve_cnt <= '0;
    else if (FIXED_PRIO == 0)            starve_cnt <= '0;
    else if (!req1_valid || req1_ready)  starve_cnt <= '0;
    else if (!starve_hit)                starve_cnt <= starve_cnt + 1'b1;
  end

  assign busy = rsp_valid;

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed self-checking bench for alu_arbiter (round-robin and fixed-priority instances).
module tb_alu_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req0_valid, req1_valid;
  logic [31:0] req0_a, req0_b, req1_a, req1_b;
  logic [3:0]  req0_sel, req1_sel;
  logic        rsp_ready;

  logic        req0_ready, req1_ready, rsp_valid, rsp_id, busy;
  logic [31:0] rsp_data;
  logic        fp_req0_ready, fp_req1_ready, fp_rsp_valid, fp_rsp_id, fp_busy;
  logic [31:0] fp_rsp_data;

  int tests_run = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  alu_arbiter #(.FIXED_PRIO(0), .STARVE_LIMIT(15)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b), .req0_sel(req0_sel),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b), .req1_sel(req1_sel),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_data(rsp_data), .busy(busy)
  );

  alu_arbiter #(.FIXED_PRIO(1), .STARVE_LIMIT(3)) dut_fp (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(fp_req0_ready), .req0_a(req0_a), .req0_b(req0_b), .req0_sel(req0_sel),
    .req1_valid(req1_valid), .req1_ready(fp_req1_ready), .req1_a(req1_a), .req1_b(req1_b), .req1_sel(req1_sel),
    .rsp_valid(fp_rsp_valid), .rsp_ready(rsp_ready), .rsp_id(fp_rsp_id), .rsp_data(fp_rsp_data), .busy(fp_busy)
  );

  task automatic set0(input logic v, input logic [3:0] s, input logic [31:0] a, input logic [31:0] b);
    req0_valid = v; req0_sel = s; req0_a = a; req0_b = b;
  endtask

  task automatic set1(input logic v, input logic [3:0] s, input logic [31:0] a, input logic [31:0] b);
    req1_valid = v; req1_sel = s; req1_a = a; req1_b = b;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    set0(1'b1, 4'b0000, 32'd1, 32'd1);
    set1(1'b1, 4'b0000, 32'd2, 32'd2);
    rsp_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    tests_run++;
    if ({rsp_valid, busy, rsp_id} !== 3'b000) begin
      tests_failed++; $display("FAIL reset_flags: got valid/busy/id=%b expected 000", {rsp_valid, busy, rsp_id});
    end
    tests_run++;
    if (rsp_data !== 32'd0) begin
      tests_failed++; $display("FAIL reset_data: got %h expected 00000000", rsp_data);
    end
    tests_run++;
    if ({req0_ready, req1_ready, fp_req0_ready, fp_req1_ready} !== 4'b0000) begin
      tests_failed++; $display("FAIL reset_ready: got %b expected 0000", {req0_ready, req1_ready, fp_req0_ready, fp_req1_ready});
    end
  endtask

  // Both valid right out of reset: req0 first, then req1, then req0 again.
  task automatic test_round_robin;
    logic [31:0] exp_d [3];
    logic        exp_g [3];
    exp_d = '{32'd12, 32'd7, 32'd12};
    exp_g = '{1'b0, 1'b1, 1'b0};
    @(negedge clk);
    rst_n = 1'b1;
    set0(1'b1, 4'b0000, 32'd5, 32'd7);
    set1(1'b1, 4'b0001, 32'd10, 32'd3);
    rsp_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      tests_run++;
      if ({req0_ready, req1_ready} !== {!exp_g[i], exp_g[i]}) begin
        tests_failed++; $display("FAIL rr_grant[%0d]: got r0/r1=%b%b expected %b%b", i, req0_ready, req1_ready, !exp_g[i], exp_g[i]);
      end
      @(posedge clk); #1;
      tests_run++;
      if (rsp_valid !== 1'b1 || rsp_data !== exp_d[i] || rsp_id !== exp_g[i]) begin
        tests_failed++; $display("FAIL rr_rsp[%0d]: got v=%b d=%0d id=%b expected v=1 d=%0d id=%b", i, rsp_valid, rsp_data, rsp_id, exp_d[i], exp_g[i]);
      end
      @(negedge clk);
    end
  endtask

  // Stall the consumer for four cycles, then release with requests pending.
  task automatic test_backpressure;
    set0(1'b1, 4'b0000, 32'd100, 32'd1);
    set1(1'b0, 4'b0000, 32'd0, 32'd0);
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    tests_run++;
    if (rsp_data !== 32'd101 || rsp_id !== 1'b0) begin
      tests_failed++; $display("FAIL bp_load: got d=%0d id=%b expected d=101 id=0", rsp_data, rsp_id);
    end
    @(negedge clk);
    set1(1'b1, 4'b0000, 32'd1, 32'd1);
    rsp_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #1;
      tests_run++;
      if ({req0_ready, req1_ready} !== 2'b00) begin
        tests_failed++; $display("FAIL bp_ready[%0d]: got %b%b expected 00", i, req0_ready, req1_ready);
      end
      @(posedge clk); #1;
      tests_run++;
      if (rsp_valid !== 1'b1 || rsp_data !== 32'd101 || rsp_id !== 1'b0) begin
        tests_failed++; $display("FAIL bp_hold[%0d]: got v=%b d=%0d id=%b expected v=1 d=101 id=0", i, rsp_valid, rsp_data, rsp_id);
      end
      @(negedge clk);
    end
    rsp_ready = 1'b1;
    #1;
    tests_run++;
    if ({req0_ready, req1_ready} !== 2'b01) begin
      tests_failed++; $display("FAIL bp_release_ready: got %b%b expected 01", req0_ready, req1_ready);
    end
    @(posedge clk); #1;
    tests_run++;
    if (rsp_valid !== 1'b1 || rsp_data !== 32'd2 || rsp_id !== 1'b1) begin
      tests_failed++; $display("FAIL bp_release_rsp: got v=%b d=%0d id=%b expected v=1 d=2 id=1", rsp_valid, rsp_data, rsp_id);
    end
    @(negedge clk);
  endtask

  // Operation table, including shift-amount masking.
  task automatic test_ops;
    logic [3:0]  sel [8];
    logic [31:0] va  [8];
    logic [31:0] vb  [8];
    logic [31:0] ve  [8];
    sel = '{4'b0010, 4'b1011, 4'b1010, 4'b0100, 4'b0110, 4'b1000, 4'b1100, 4'b1110};
    va  = '{32'h1, 32'h80000000, 32'h80000000, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hF0F0F0F0, 32'hF0F00000, 32'hFF00FF00};
    vb  = '{32'h21, 32'd31, 32'h24, 32'h1, 32'h1, 32'hFFFF0000, 32'h0000000F, 32'h0FF00FF0};
    ve  = '{32'h2, 32'hFFFFFFFF, 32'h08000000, 32'h1, 32'h0, 32'h0F0FF0F0, 32'hF0F0000F, 32'h0F000F00};
    set1(1'b0, 4'b0000, 32'd0, 32'd0);
    rsp_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      set0(1'b1, sel[i], va[i], vb[i]);
      @(posedge clk); #1;
      tests_run++;
      if (rsp_data !== ve[i] || rsp_id !== 1'b0) begin
        tests_failed++; $display("FAIL op_sel%b: got %h id=%b expected %h id=0", sel[i], rsp_data, rsp_id, ve[i]);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_undefined;
    set0(1'b1, 4'b0101, 32'd2, 32'd3);
    @(posedge clk); #1;
    tests_run++;
    if (rsp_data !== 32'd5) begin
      tests_failed++; $display("FAIL op_undefined: got %0d expected 5", rsp_data);
    end
    @(negedge clk);
  endtask

  task automatic test_drain;
    set0(1'b0, 4'b0000, 32'd0, 32'd0);
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    tests_run++;
    if (rsp_valid !== 1'b0 || busy !== 1'b0 || rsp_data !== 32'd5) begin
      tests_failed++; $display("FAIL drain: got v=%b busy=%b d=%0d expected v=0 busy=0 d=5", rsp_valid, busy, rsp_data);
    end
    @(negedge clk);
  endtask

  // Asynchronous reset while a result is stalled, then a clean tie afterwards.
  task automatic test_reset_mid;
    set0(1'b1, 4'b0000, 32'd1, 32'd2);
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    set0(1'b0, 4'b0000, 32'd0, 32'd0);
    rsp_ready = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    tests_run++;
    if (rsp_valid !== 1'b0 || rsp_data !== 32'd0 || busy !== 1'b0) begin
      tests_failed++; $display("FAIL async_reset: got v=%b d=%0d busy=%b expected v=0 d=0 busy=0", rsp_valid, rsp_data, busy);
    end
    @(negedge clk);
    rsp_ready = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    set0(1'b1, 4'b0000, 32'd20, 32'd22);
    set1(1'b1, 4'b0001, 32'd9, 32'd4);
    #1;
    tests_run++;
    if ({req0_ready, req1_ready} !== 2'b10) begin
      tests_failed++; $display("FAIL post_reset_tie: got %b%b expected 10", req0_ready, req1_ready);
    end
    @(posedge clk); #1;
    tests_run++;
    if (rsp_valid !== 1'b1 || rsp_data !== 32'd42 || rsp_id !== 1'b0) begin
      tests_failed++; $display("FAIL post_reset_rsp: got v=%b d=%0d id=%b expected v=1 d=42 id=0", rsp_valid, rsp_data, rsp_id);
    end
    @(negedge clk);
  endtask

  // Fixed priority with STARVE_LIMIT=3: pattern 0,0,0,1 repeating.
  task automatic test_fixed_prio;
    logic exp_g;
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    set0(1'b1, 4'b0000, 32'd1, 32'd0);
    set1(1'b1, 4'b0000, 32'd2, 32'd0);
    rsp_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      exp_g = ((i % 4) == 3);
      #1;
      tests_run++;
      if ({fp_req0_ready, fp_req1_ready} !== {!exp_g, exp_g}) begin
        tests_failed++; $display("FAIL fp_grant[%0d]: got r0/r1=%b%b expected %b%b", i, fp_req0_ready, fp_req1_ready, !exp_g, exp_g);
      end
      @(posedge clk); #1;
      tests_run++;
      if (fp_rsp_id !== exp_g || fp_rsp_data !== (exp_g ? 32'd2 : 32'd1)) begin
        tests_failed++; $display("FAIL fp_rsp[%0d]: got id=%b d=%0d expected id=%b d=%0d", i, fp_rsp_id, fp_rsp_data, exp_g, exp_g ? 2 : 1);
      end
      @(negedge clk);
    end
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_backpressure();
    test_ops();
    test_undefined();
    test_drain();
    test_reset_mid();
    test_fixed_prio();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 SHALL have parameter FIXED_PRIO, default 0; 0 = round-robin, 1 = requester 0 wins unless starvation rule applies.
REQ-002 SHALL have parameter STARVE_LIMIT, default 15; wait cycles after which requester 1 is forced a grant in FIXED_PRIO mode.
REQ-003 SHALL have port clk  input  1  sole clock, all state on rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have ports req0_valid/req1_valid  input  1  operation request from requester 0/1.
REQ-006 SHALL have ports req0_ready/req1_ready  output  1  request accepted this cycle.
REQ-007 SHALL have ports req0_a/req1_a, req0_b/req1_b  input  32  signed operands A/B.
REQ-008 SHALL have ports req0_sel/req1_sel  input  4  ALU operation code (alu_pkg encodings).
REQ-009 SHALL have port rsp_valid  output  1  result register holds a result.
REQ-010 SHALL have port rsp_ready  input  1  consumer takes result this cycle.
REQ-011 SHALL have port rsp_id  output  1  requester index owning rsp_data.
REQ-012 SHALL have port rsp_data  output  32  registered ALU result.
REQ-013 SHALL have port busy  output  1  equals rsp_valid.

Function
REQ-014 SHALL accept a request only when slot free: !rsp_valid or (rsp_valid and rsp_ready); sustained throughput 1 op/cycle.
REQ-015 SHALL assert at most one reqN_ready per cycle, only for a valid requester that is granted.
REQ-016 Round-robin: both valid -> grant requester not granted last; one valid -> grant it; last_grant updates only on accept.
REQ-017 FIXED_PRIO=1: requester 0 wins ties, except when starve counter >= STARVE_LIMIT, then requester 1 wins.
REQ-018 Starve counter SHALL increment each cycle req1_valid is high and not accepted, saturate at STARVE_LIMIT, clear when req1 accepted or req1_valid low; inactive (held 0) when FIXED_PRIO=0.
REQ-019 Accepted operands SHALL drive the ALU combinationally; result and id registered at next edge (latency 1 cycle).
REQ-020 For sel 0010, 1010, 1011 (shifts) operand B SHALL be masked to bits [4:0] before the ALU.
REQ-021 Unknown sel codes SHALL produce A+B (ALU default).
REQ-022 rsp_data/rsp_id SHALL hold stable while rsp_valid and !rsp_ready.
REQ-023 Drain and accept in same cycle: new result replaces old at edge, rsp_valid stays 1.
REQ-024 Drain with no accept: rsp_valid falls to 0 next edge; rsp_data retains last value.
REQ-025 reqN_ready may depend combinationally on reqN_valid and rsp_ready; no combinational path from reqN operands to readies.

Reset
REQ-026 While rst_n low: rsp_valid=0, rsp_data=0, rsp_id=0, req0_ready=req1_ready=0, last_grant=1 (requester 0 wins first tie), starve counter=0.
REQ-027 Reset asserted mid-operation SHALL discard any pending result immediately (asynchronously); no result delivered after release for pre-reset requests.
REQ-028 First accept SHALL be possible on the first rising edge after rst_n deasserts.

Structure
REQ-029 Package alu_pkg SHALL hold XLEN=32 and named 4-bit sel constants (ADD 0000, SUB 0001, SLL 0010, SLT 0100, SLTU 0110, XOR 1000, SRL 1010, SRA 1011, OR 1100, AND 1110).
REQ-030 SHALL instantiate exactly one sub-module, ALU, as the shared datapath; arbitration, masking and result register live in alu_arbiter.

Verification
REQ-031 Both valid from reset, rsp_ready=1, req0 ADD 5,7, req1 SUB 10,3 -> cycle1 req0 granted, rsp 12 id0; cycle2 req1 granted, rsp 7 id1.
REQ-032 rsp_ready=0 with rsp_valid=1 for 4 cycles -> both readies 0, rsp_data/rsp_id unchanged; raising rsp_ready with req pending -> accept same cycle, no bubble.
REQ-033 req0 SLL A=1, B=0x00000021 -> rsp_data=0x00000002 (shift masked to 1); SRA A=0x80000000, B=31 -> 0xFFFFFFFF.
REQ-034 FIXED_PRIO=1, STARVE_LIMIT=3, both valid continuously -> req0 granted 3 times, then req1 granted once, counter cleared, pattern repeats.
REQ-035 rst_n pulsed low while rsp_valid=1 and rsp_ready=0 -> rsp_valid=0 immediately, no stale result after release, first tie goes to req0.
REQ-036 sel=0101 (undefined), A=2, B=3 -> rsp_data=5.
